// File: rtl/ram_ctrl_pkg.sv
// Shared types and helpers for the single-port-pair RAM controller.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    START,
    INIT,
    RUN
  } state_e;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) begin
      r++;
    end
    return r;
  endfunction

  // Index of the set bit in a one-hot vector of up to 8 bits; 0 when empty.
  function automatic int unsigned oh_to_idx(input logic [7:0] oh);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (oh[i]) r = i;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after base+1 wins.
module rr_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_valid
);

  int unsigned cand;

  always_comb begin
    gnt  = '0;
    cand = 0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = (32'(base) + k) % N;
      if (gnt == '0 && req[cand]) gnt[cand] = 1'b1;
    end
    gnt_valid = |gnt;
    gnt_idx   = IW'(oh_to_idx(8'(gnt)));
  end

endmodule

// File: rtl/ram_1w_1rs_ctrl.sv
// Owns a 1-write/1-read RAM: zero-fills it after reset, then serves one writer
// and READERS round-robin read requesters, stalling reads that hit the write address.
module ram_1w_1rs_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter  int WORD_COUNT = 256,
  parameter  int WORD_WIDTH = 32,
  parameter  int MASK_WIDTH = 4,
  parameter  int READERS    = 2,
  localparam int AW         = clog2(WORD_COUNT)
) (
  input  logic                    clk,
  input  logic                    resetn,
  output logic                    init_busy,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WORD_WIDTH-1:0]   wr_data,
  input  logic [MASK_WIDTH-1:0]   wr_mask,
  input  logic [READERS-1:0]      rd_cmd_valid,
  output logic [READERS-1:0]      rd_cmd_ready,
  input  logic [READERS*AW-1:0]   rd_cmd_addr,
  output logic [READERS-1:0]      rd_rsp_valid,
  output logic [WORD_WIDTH-1:0]   rd_rsp_data,
  output logic                    ram_wr_en,
  output logic [MASK_WIDTH-1:0]   ram_wr_mask,
  output logic [AW-1:0]           ram_wr_addr,
  output logic [WORD_WIDTH-1:0]   ram_wr_data,
  output logic                    ram_rd_en,
  output logic [AW-1:0]           ram_rd_addr,
  input  logic [WORD_WIDTH-1:0]   ram_rd_data
);

  localparam int          IW        = (READERS > 1) ? clog2(READERS) : 1;
  localparam logic [AW:0] LAST_ADDR = (AW + 1)'(WORD_COUNT - 1);

  state_e              state_q, state_d;
  logic [AW:0]         init_cnt_q, init_cnt_d;
  logic [IW-1:0]       last_grant_q, last_grant_d;
  logic [READERS-1:0]  rsp_valid_q, rsp_valid_d;

  logic [READERS-1:0]  arb_gnt;
  logic [IW-1:0]       arb_idx;
  logic                arb_valid;
  logic [AW-1:0]       cand_addr;
  logic                wr_fire;
  logic                hazard;

  rr_arbiter #(.N(READERS)) u_arb (
    .req       (rd_cmd_valid),
    .base      (last_grant_q),
    .gnt       (arb_gnt),
    .gnt_idx   (arb_idx),
    .gnt_valid (arb_valid)
  );

  always_comb begin
    cand_addr = '0;
    for (int unsigned i = 0; i < READERS; i++) begin
      if (arb_gnt[i]) cand_addr = rd_cmd_addr[i*AW +: AW];
    end
  end

  always_comb begin
    state_d      = state_q;
    init_cnt_d   = init_cnt_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = '0;
    init_busy    = 1'b1;
    wr_ready     = 1'b0;
    rd_cmd_ready = '0;
    ram_wr_en    = 1'b0;
    ram_wr_mask  = '0;
    ram_wr_addr  = '0;
    ram_wr_data  = '0;
    ram_rd_en    = 1'b0;
    ram_rd_addr  = '0;
    wr_fire      = 1'b0;
    hazard       = 1'b0;

    unique case (state_q)
      START: state_d = INIT;
      INIT: begin
        ram_wr_en   = 1'b1;
        ram_wr_mask = '1;
        ram_wr_addr = init_cnt_q[AW-1:0];
        init_cnt_d  = init_cnt_q + (AW + 1)'(1);
        if (init_cnt_q == LAST_ADDR) state_d = RUN;
      end
      RUN: begin
        init_busy = 1'b0;
        wr_ready  = 1'b1;
        wr_fire   = wr_valid;
        if (wr_fire) begin
          ram_wr_en   = 1'b1;
          ram_wr_mask = wr_mask;
          ram_wr_addr = wr_addr;
          ram_wr_data = wr_data;
        end
        // A colliding write suppresses the whole grant; the pointer holds so the same reader retries.
        hazard = wr_fire && (wr_addr == cand_addr);
        if (arb_valid && !hazard) begin
          rd_cmd_ready = arb_gnt;
          ram_rd_en    = 1'b1;
          ram_rd_addr  = cand_addr;
          last_grant_d = arb_idx;
          rsp_valid_d  = arb_gnt;
        end
      end
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= START;
      init_cnt_q   <= '0;
      last_grant_q <= IW'(READERS - 1);
      rsp_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      init_cnt_q   <= init_cnt_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
    end
  end

  assign rd_rsp_valid = rsp_valid_q;
  assign rd_rsp_data  = ram_rd_data;

endmodule

// File: doc/ram_1w_1rs_ctrl.md
# ram_1w_1rs_ctrl

Controller that owns one `Ram_1w_1rs` instance (1-cycle registered read) and shares it between one writer and `READERS` read requesters. After reset it zero-initialises every word through the write port. It then arbitrates read requests round-robin, one per cycle, and steers the 1-cycle-late read data back to the granted requester. Read/write same-address hazards are resolved by stalling the read.

## Interface
Parameters:
- `WORD_COUNT`, 256: RAM depth, power of two, ≥ 2.
- `WORD_WIDTH`, 32: data width.
- `MASK_WIDTH`, 4: byte-lane count; `WORD_WIDTH % MASK_WIDTH == 0`.
- `READERS`, 2: number of read requesters, 1..8.
- `AW` (localparam) = clog2(`WORD_COUNT`).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `init_busy`  out  1  high from reset until the clear sweep completes.
- `wr_valid`, `wr_ready`  in/out  1  write handshake.
- `wr_addr` in AW; `wr_data` in WORD_WIDTH; `wr_mask` in MASK_WIDTH.
- `rd_cmd_valid`, `rd_cmd_ready`  in/out  READERS  per-requester read command handshake.
- `rd_cmd_addr`  in  READERS*AW  requester i occupies bits [i*AW +: AW].
- `rd_rsp_valid`  out  READERS  one-hot; response belongs to that requester.
- `rd_rsp_data`  out  WORD_WIDTH  shared response data.
- `ram_wr_en` out 1; `ram_wr_mask` out MASK_WIDTH; `ram_wr_addr` out AW; `ram_wr_data` out WORD_WIDTH.
- `ram_rd_en` out 1; `ram_rd_addr` out AW; `ram_rd_data` in WORD_WIDTH.

## Operation
- FSM states:
  - START (reset state) → INIT, unconditionally after one cycle.
  - INIT → RUN after writing address WORD_COUNT-1.
  - RUN is terminal.
- START:
  - All RAM enables are 0; all `*_ready` are 0; `init_busy` = 1.
- INIT:
  - Each cycle: `ram_wr_en`=1, `ram_wr_mask` all ones, `ram_wr_data`=0, `ram_wr_addr`=`init_cnt`.
  - `init_cnt` starts at 0 and increments by 1 per cycle.
  - `wr_ready`=0, `rd_cmd_ready`=0, `init_busy`=1.
- RUN, writes:
  - `wr_ready`=1; a write fires when `wr_valid` is high.
  - On a fire: `ram_wr_en`=1, and addr, data and mask pass straight through.
  - Writes never stall.
- RUN, reads:
  - The arbiter selects the first requester with `rd_cmd_valid` set, searching upward from `last_grant+1` modulo READERS.
  - Hazard: if a write fires this cycle and `wr_addr` equals the candidate's address, no grant is issued. All `rd_cmd_ready`=0, `ram_rd_en`=0, and `last_grant` is unchanged.
  - Otherwise the winner gets `rd_cmd_ready[w]`=1, `ram_rd_en`=1, `ram_rd_addr` = its address, and `last_grant` becomes w.
  - `rd_cmd_ready` is combinational and at most one-hot; it is 0 for any requester without valid.
- Response:
  - The grant index is registered, so `rd_rsp_valid` = one-hot(granted) on the cycle after the grant.
  - `rd_rsp_data` = `ram_rd_data` (combinational passthrough).
  - No backpressure: requesters must accept the response.
- `ram_wr_*` and `ram_rd_addr` are don't-care when their enable is 0; drive 0.

## Timing
- Reset values: state=START, `init_cnt`=0, `last_grant`=READERS-1 (so requester 0 wins first), `rd_rsp_valid`=0, `init_busy`=1.
- While `resetn` is low, `ram_wr_en`=0 and `ram_rd_en`=0.
- `init_busy` falls on the cycle the FSM enters RUN, which is WORD_COUNT+1 cycles after reset deassertion.
- `wr_ready` and `rd_cmd_ready` may go high in that same cycle.
- Read latency is exactly 1 cycle, grant to `rd_rsp_valid`. Throughput is 1 read per cycle.
- A write and a read to different addresses proceed in the same cycle.
- A read to an address written in an earlier cycle returns the new data.
- `init_cnt` is AW+1 bits wide so the terminal compare does not wrap.
- Reset mid-INIT: the sweep restarts from address 0.
- Reset with a response in flight: the response is dropped and `rd_rsp_valid`=0.
- Writer starvation of readers through a continuous same-address hazard is permitted; the writer has priority by design.

## Structure
- Package `ram_ctrl_pkg`:
  - state enum {START, INIT, RUN};
  - `clog2` function;
  - one-hot-to-index helper.
- Sub-module `rr_arbiter` (parameter N):
  - inputs `req[N]`, `base` pointer;
  - outputs one-hot `gnt` and index;
  - purely combinational.
- The `last_grant` register stays in `ram_1w_1rs_ctrl`.

## Test plan
- Reset, WORD_COUNT=16:
  - `init_busy` is high for 17 cycles;
  - addresses 0..15 are written with 0 and full mask;
  - then every read of every address returns 0.
- Write 0xDEADBEEF to addr 5 with mask 4'b0011, then read addr 5 from requester 1:
  - response 0x0000BEEF;
  - `rd_rsp_valid` = 2'b10 exactly one cycle after the grant.
- Both requesters hold valid continuously, READERS=2:
  - grants alternate 0,1,0,1 starting with 0;
  - one response per cycle, each correctly tagged.
- Write addr 7 and a read of addr 7 in the same cycle:
  - read is not granted that cycle;
  - read is granted the next cycle and returns the new data.
- Write addr 3 while reading addr 4 in the same cycle:
  - both fire;
  - the read returns the old value of addr 4.
- Assert `resetn` low at init address 9:
  - after release the sweep restarts at address 0;
  - `rd_rsp_valid` is 0 throughout.
